// File: rtl/flipper_pkg.sv
// Shared types and screen constants for the ball and flipper controllers.
package flipper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RISE,
    HOLD,
    FALL
  } kick_state_t;

  localparam int FRAC_BITS_DEFAULT = 6;
  localparam int X_FRAME_SIZE      = 639;
  localparam int Y_FRAME_SIZE      = 479;

endpackage

// File: rtl/flipper_kick_fsm.sv
// Vertical kick animation: key5 edge detect, request latch, rise/hold/fall FSM.
module flipper_kick_fsm
  import flipper_pkg::*;
#(
  parameter int KICK_HEIGHT      = 16,
  parameter int KICK_STEP        = 4,
  parameter int KICK_HOLD_FRAMES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        key5IsPressed,
  output logic [10:0] kickOffset,
  output logic        kickActive
);

  localparam logic [15:0] HOLD_LAST = 16'(KICK_HOLD_FRAMES - 1);

  kick_state_t stateReg, stateNext;
  logic [10:0] offsetReg, offsetNext;
  logic [15:0] holdCntReg, holdCntNext;
  logic        key5PrevReg;
  logic        pendingReg, pendingNext;
  logic        key5Rise;
  logic        kickReq;
  int          raised;
  int          lowered;

  assign key5Rise = key5IsPressed & ~key5PrevReg;
  assign kickReq  = pendingReg | key5Rise;

  // offsetReg is 0 in IDLE, so IDLE and RISE share the same clamped step.
  assign raised  = (int'(offsetReg) + KICK_STEP >= KICK_HEIGHT) ? KICK_HEIGHT
                                                                : int'(offsetReg) + KICK_STEP;
  assign lowered = (int'(offsetReg) - KICK_STEP <= 0) ? 0 : int'(offsetReg) - KICK_STEP;

  always_comb begin
    stateNext   = stateReg;
    offsetNext  = offsetReg;
    holdCntNext = holdCntReg;
    pendingNext = pendingReg | key5Rise;
    if (startOfFrame) begin
      // A request is either consumed here or dropped; it never waits for IDLE.
      pendingNext = 1'b0;
      case (stateReg)
        IDLE, RISE: begin
          if (stateReg == RISE || kickReq) begin
            offsetNext = 11'(raised);
            if (raised == KICK_HEIGHT) begin
              stateNext   = HOLD;
              holdCntNext = '0;
            end else begin
              stateNext = RISE;
            end
          end
        end
        HOLD: begin
          if (holdCntReg == HOLD_LAST) stateNext = FALL;
          else holdCntNext = holdCntReg + 16'd1;
        end
        FALL: begin
          offsetNext = 11'(lowered);
          if (lowered == 0) stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg    <= IDLE;
      offsetReg   <= '0;
      holdCntReg  <= '0;
      key5PrevReg <= 1'b0;
      pendingReg  <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      offsetReg   <= offsetNext;
      holdCntReg  <= holdCntNext;
      key5PrevReg <= key5IsPressed;
      pendingReg  <= pendingNext;
    end
  end

  assign kickOffset = offsetReg;
  assign kickActive = (stateReg != IDLE);

endmodule

// File: rtl/flipper_motion_controller.sv
// Per-frame flipper motion: fixed-point velocity with accel/friction/saturation,
// wall clamping, and a vertical kick offset from flipper_kick_fsm.
module flipper_motion_controller
  import flipper_pkg::*;
#(
  parameter int FRAC_BITS        = FRAC_BITS_DEFAULT,
  parameter int INITIAL_X        = 280,
  parameter int INITIAL_Y        = 50,
  parameter int X_MIN            = 0,
  parameter int X_MAX            = 560,
  parameter int MAX_SPEED        = 512,
  parameter int ACCEL            = 64,
  parameter int FRICTION         = 32,
  parameter int KICK_HEIGHT      = 16,
  parameter int KICK_STEP        = 4,
  parameter int KICK_HOLD_FRAMES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               key4IsPressed,
  input  logic               key6IsPressed,
  input  logic               key5IsPressed,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic signed [15:0] speedX,
  output logic               kickActive,
  output logic               atLeftWall,
  output logic               atRightWall
);

  localparam logic signed [31:0] M        = 32'sd1 <<< FRAC_BITS;
  localparam logic signed [31:0] MIN_POS  = X_MIN * M;
  localparam logic signed [31:0] MAX_POS  = X_MAX * M;
  localparam logic signed [31:0] INIT_POS = INITIAL_X * M;
  localparam logic signed [31:0] VMAX     = MAX_SPEED;
  localparam logic signed [31:0] ACC      = ACCEL;
  localparam logic signed [31:0] FRIC     = FRICTION;

  if (!(X_MIN <= INITIAL_X && INITIAL_X <= X_MAX)) begin : gBadInitialX
    $fatal(1, "INITIAL_X outside [X_MIN, X_MAX]");
  end
  if (KICK_STEP <= 0) begin : gBadKickStep
    $fatal(1, "KICK_STEP must be positive");
  end
  if (KICK_HOLD_FRAMES < 1) begin : gBadHoldFrames
    $fatal(1, "KICK_HOLD_FRAMES must be at least 1");
  end
  if (MAX_SPEED >= (1 << 15)) begin : gBadMaxSpeed
    $fatal(1, "MAX_SPEED must fit in speedX");
  end

  logic signed [31:0] posXReg, posXNext;
  logic signed [31:0] velXReg, velXNext;
  logic signed [31:0] velCand, posCand;
  logic        [10:0] kickOffset;

  always_comb begin
    velCand = velXReg;
    if (key4IsPressed ^ key6IsPressed) begin
      if (key4IsPressed) velCand = (velXReg + ACC > VMAX) ? VMAX : velXReg + ACC;
      else               velCand = (velXReg - ACC < -VMAX) ? -VMAX : velXReg - ACC;
    end else if (velXReg > FRIC) begin
      velCand = velXReg - FRIC;
    end else if (velXReg < -FRIC) begin
      velCand = velXReg + FRIC;
    end else begin
      velCand = '0;
    end

    // Position uses this frame's new velocity; hitting a wall kills velocity.
    posCand  = posXReg + velCand;
    posXNext = posCand;
    velXNext = velCand;
    if (posCand < MIN_POS) begin
      posXNext = MIN_POS;
      velXNext = '0;
    end else if (posCand > MAX_POS) begin
      posXNext = MAX_POS;
      velXNext = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      posXReg <= INIT_POS;
      velXReg <= '0;
    end else if (startOfFrame) begin
      posXReg <= posXNext;
      velXReg <= velXNext;
    end
  end

  flipper_kick_fsm #(
    .KICK_HEIGHT      (KICK_HEIGHT),
    .KICK_STEP        (KICK_STEP),
    .KICK_HOLD_FRAMES (KICK_HOLD_FRAMES)
  ) uKick (
    .clk           (clk),
    .reset         (reset),
    .startOfFrame  (startOfFrame),
    .key5IsPressed (key5IsPressed),
    .kickOffset    (kickOffset),
    .kickActive    (kickActive)
  );

  assign topLeftX    = 11'(posXReg >>> FRAC_BITS);
  assign topLeftY    = 11'(INITIAL_Y - int'(kickOffset));
  assign speedX      = velXReg[15:0];
  assign atLeftWall  = (posXReg == MIN_POS);
  assign atRightWall = (posXReg == MAX_POS);

endmodule

// File: tb/tb_flipper_motion_controller.sv
// Directed self-checking bench for flipper_motion_controller (default parameters).
module tb_flipper_motion_controller;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               startOfFrame = 1'b0;
  logic               key4IsPressed = 1'b0;
  logic               key6IsPressed = 1'b0;
  logic               key5IsPressed = 1'b0;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic signed [15:0] speedX;
  logic               kickActive;
  logic               atLeftWall;
  logic               atRightWall;

  int errors = 0;
  int checks = 0;
  int frameNum = 0;

  flipper_motion_controller dut (
    .clk           (clk),
    .reset         (reset),
    .startOfFrame  (startOfFrame),
    .key4IsPressed (key4IsPressed),
    .key6IsPressed (key6IsPressed),
    .key5IsPressed (key5IsPressed),
    .topLeftX      (topLeftX),
    .topLeftY      (topLeftY),
    .speedX        (speedX),
    .kickActive    (kickActive),
    .atLeftWall    (atLeftWall),
    .atRightWall   (atRightWall)
  );

  always #5 clk = ~clk;

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; startOfFrame = 1'b0;
    key4IsPressed = 1'b0; key6IsPressed = 1'b0; key5IsPressed = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One startOfFrame pulse; outputs are sampled on the following negedge.
  task automatic frame();
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    frameNum++;
    $display("frame %0d: x=%0d y=%0d v=%0d kick=%0b lw=%0b rw=%0b",
             frameNum, topLeftX, topLeftY, speedX, kickActive, atLeftWall, atRightWall);
  endtask

  task automatic pulseKey5();
    @(negedge clk);
    key5IsPressed = 1'b1;
    @(negedge clk);
    key5IsPressed = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (topLeftX !== 11'sd280) begin errors++; $display("FAIL reset_x got %0d want 280", topLeftX); end
    checks++; if (topLeftY !== 11'sd50) begin errors++; $display("FAIL reset_y got %0d want 50", topLeftY); end
    checks++; if (speedX !== 16'sd0) begin errors++; $display("FAIL reset_speed got %0d want 0", speedX); end
    checks++; if (kickActive !== 1'b0) begin errors++; $display("FAIL reset_kick got %b want 0", kickActive); end
    checks++; if (atLeftWall !== 1'b0) begin errors++; $display("FAIL reset_lwall got %b want 0", atLeftWall); end
    checks++; if (atRightWall !== 1'b0) begin errors++; $display("FAIL reset_rwall got %b want 0", atRightWall); end

    // Reset mid-kick and mid-motion, landing on frame 5.
    key4IsPressed = 1'b1;
    pulseKey5();
    repeat (4) frame();
    checks++; if (topLeftY !== 11'sd34) begin errors++; $display("FAIL midkick_y got %0d want 34", topLeftY); end
    @(negedge clk);
    reset = 1'b1; startOfFrame = 1'b1;
    @(negedge clk);
    reset = 1'b0; startOfFrame = 1'b0; key4IsPressed = 1'b0;
    checks++; if (topLeftX !== 11'sd280) begin errors++; $display("FAIL rst2_x got %0d want 280", topLeftX); end
    checks++; if (topLeftY !== 11'sd50) begin errors++; $display("FAIL rst2_y got %0d want 50", topLeftY); end
    checks++; if (speedX !== 16'sd0) begin errors++; $display("FAIL rst2_speed got %0d want 0", speedX); end
    checks++; if (kickActive !== 1'b0) begin errors++; $display("FAIL rst2_kick got %b want 0", kickActive); end
    frame();
    checks++; if (topLeftY !== 11'sd50) begin errors++; $display("FAIL rst2_nokick_y got %0d want 50", topLeftY); end
  endtask

  task automatic test_accel();
    int expV[3] = '{64, 128, 192};
    int expX[3] = '{281, 283, 286};
    doReset();
    key4IsPressed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frame();
      checks++; if (speedX !== 16'(expV[i])) begin errors++; $display("FAIL accel_v[%0d] got %0d want %0d", i, speedX, expV[i]); end
      checks++; if (topLeftX !== 11'(expX[i])) begin errors++; $display("FAIL accel_x[%0d] got %0d want %0d", i, topLeftX, expX[i]); end
    end
    key4IsPressed = 1'b0;
  endtask

  task automatic test_sat_friction();
    int expV;
    int both[4] = '{96, 64, 32, 0};
    doReset();
    key4IsPressed = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      frame();
      expV = (64 * i > 512) ? 512 : 64 * i;
      checks++; if (speedX !== 16'(expV)) begin errors++; $display("FAIL sat_v[%0d] got %0d want %0d", i, speedX, expV); end
    end
    key4IsPressed = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      frame();
      expV = (512 - 32 * i < 0) ? 0 : 512 - 32 * i;
      checks++; if (speedX !== 16'(expV)) begin errors++; $display("FAIL fric_v[%0d] got %0d want %0d", i, speedX, expV); end
    end
    key4IsPressed = 1'b1;
    repeat (2) frame();
    checks++; if (speedX !== 16'sd128) begin errors++; $display("FAIL both_pre_v got %0d want 128", speedX); end
    key6IsPressed = 1'b1;
    for (int i = 0; i < 4; i++) begin
      frame();
      checks++; if (speedX !== 16'(both[i])) begin errors++; $display("FAIL both_v[%0d] got %0d want %0d", i, speedX, both[i]); end
    end
    key4IsPressed = 1'b0; key6IsPressed = 1'b0;
  endtask

  task automatic test_walls();
    bit reached;
    doReset();
    key6IsPressed = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 150 && !reached; i++) begin
      frame();
      if (topLeftX == 11'sd0) reached = 1'b1;
    end
    checks++; if (!reached) begin errors++; $display("FAIL lwall_reach got x=%0d want 0 within 150 frames", topLeftX); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (topLeftX !== 11'sd0) begin errors++; $display("FAIL lwall_x[%0d] got %0d want 0", i, topLeftX); end
      checks++; if (speedX !== 16'sd0) begin errors++; $display("FAIL lwall_v[%0d] got %0d want 0", i, speedX); end
      checks++; if (atLeftWall !== 1'b1) begin errors++; $display("FAIL lwall_flag[%0d] got %b want 1", i, atLeftWall); end
      frame();
    end
    key6IsPressed = 1'b0;

    doReset();
    key4IsPressed = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 150 && !reached; i++) begin
      frame();
      checks++; if (topLeftX > 11'sd560) begin errors++; $display("FAIL rwall_over got %0d want <= 560", topLeftX); end
      if (topLeftX == 11'sd560) reached = 1'b1;
    end
    checks++; if (!reached) begin errors++; $display("FAIL rwall_reach got x=%0d want 560 within 150 frames", topLeftX); end
    frame();
    checks++; if (topLeftX !== 11'sd560) begin errors++; $display("FAIL rwall_x got %0d want 560", topLeftX); end
    checks++; if (speedX !== 16'sd0) begin errors++; $display("FAIL rwall_v got %0d want 0", speedX); end
    checks++; if (atRightWall !== 1'b1) begin errors++; $display("FAIL rwall_flag got %b want 1", atRightWall); end
    checks++; if (atLeftWall !== 1'b0) begin errors++; $display("FAIL rwall_lflag got %b want 0", atLeftWall); end
    key4IsPressed = 1'b0;
  endtask

  // Runs an 11-frame kick profile; extraPulseAfter > 0 injects a key5 pulse after that frame.
  task automatic runKick(input string tag, input int extraPulseAfter);
    int expY[11] = '{46, 42, 38, 34, 34, 34, 34, 38, 42, 46, 50};
    for (int i = 0; i < 11; i++) begin
      frame();
      checks++; if (topLeftY !== 11'(expY[i])) begin errors++; $display("FAIL %s_y[%0d] got %0d want %0d", tag, i + 1, topLeftY, expY[i]); end
      checks++; if (kickActive !== (i < 10)) begin errors++; $display("FAIL %s_active[%0d] got %b want %b", tag, i + 1, kickActive, i < 10); end
      if (i + 1 == extraPulseAfter) pulseKey5();
    end
    for (int i = 0; i < 3; i++) begin
      frame();
      checks++; if (topLeftY !== 11'sd50) begin errors++; $display("FAIL %s_after_y[%0d] got %0d want 50", tag, i, topLeftY); end
      checks++; if (kickActive !== 1'b0) begin errors++; $display("FAIL %s_after_active[%0d] got %b want 0", tag, i, kickActive); end
    end
  endtask

  task automatic test_kick();
    doReset();
    pulseKey5();
    runKick("kick", 0);
  endtask

  task automatic test_kick_discard();
    doReset();
    pulseKey5();
    runKick("discard", 5);
    // Key held high across the whole kick: one rising edge, one kick.
    @(negedge clk);
    key5IsPressed = 1'b1;
    runKick("held", 0);
    key5IsPressed = 1'b0;
  endtask

  initial begin
    test_reset();
    test_accel();
    test_sat_friction();
    test_walls();
    test_kick();
    test_kick_discard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish want finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
